// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ps2_pkg                                                    |
// | Description : Shared PS/2 host-side constants, LED bit indices and the   |
// |               LED-controller state encoding.                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package ps2_pkg;

  // Keyboard command / reply bytes
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_ACK         = 8'hFA;
  localparam logic [7:0] PS2_RESEND      = 8'hFE;

  // Bit positions inside the Set-LED argument byte and led_state
  localparam int LED_SCROLL = 0;
  localparam int LED_NUM    = 1;
  localparam int LED_CAPS   = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_CMD = 3'd1,
    WAIT_CMD = 3'd2,
    SEND_ARG = 3'd3,
    WAIT_ARG = 3'd4,
    FAIL     = 3'd5
  } led_ctrl_state_t;

  // True for the bytes the controller may claim while waiting for a reply
  function automatic logic is_reply(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_RESEND);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ps2_rx_arbiter                                             |
// | Description : Splits the received-byte stream between the LED           |
// |               controller (ACK/RESEND replies during a wait) and the      |
// |               scan-code decoder (everything else, passed through).       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, clrn        clock, synchronous active-high clear                  |
// |   waiting          controller is in WAIT_CMD or WAIT_ARG                  |
// |   tx_busy          transmitter busy; replies are ignored while high       |
// |   rx_data/ready    byte from ps2_keyboard                                 |
// |   rx_nextdata_n    active-low pop back to ps2_keyboard                    |
// |   fwd_*            decoder-side view of the stream                        |
// |   got_ack/resend   single-cycle detection strobes for the FSM             |
// +--------------------------------------------------------------------------+
module ps2_rx_arbiter
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic       waiting,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_nextdata_n,
  output logic [7:0] fwd_data,
  output logic       fwd_ready,
  input  logic       fwd_nextdata_n,
  output logic       got_ack,
  output logic       got_resend
);

  logic r_pop;
  logic w_match;

  // r_pop blocks re-detection of the same byte while it is being popped
  assign w_match    = waiting && rx_ready && !tx_busy && !r_pop && is_reply(rx_data);
  assign got_ack    = w_match && (rx_data == PS2_ACK);
  assign got_resend = w_match && (rx_data == PS2_RESEND);

  always_ff @(posedge clk) begin
    if (clrn) begin
      r_pop <= 1'b0;
    end else begin
      r_pop <= w_match;
    end
  end

  // The decoder never sees a claimed byte: it is hidden on the detection
  // cycle and on the following pop cycle.
  assign rx_nextdata_n = r_pop ? 1'b0 : (w_match ? 1'b1 : fwd_nextdata_n);
  assign fwd_ready     = (w_match || r_pop) ? 1'b0 : rx_ready;
  assign fwd_data      = rx_data;

endmodule
`default_nettype wire

// File: rtl/ps2_led_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ps2_led_controller                                         |
// | Description : Keeps keyboard Caps/Num/Scroll LEDs in step with the      |
// |               system lock flags by issuing ED,<mask> and handling       |
// |               ACK / RESEND / reply timeout with bounded retries.          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, clrn          clock, synchronous active-high clear                |
// |   led_state          requested mask {caps,num,scroll} (level)            |
// |   tx_data/start/busy PS/2 transmitter handshake                          |
// |   rx_*               byte stream from ps2_keyboard                       |
// |   fwd_*              byte stream towards the scan-code decoder           |
// |   led_applied        last mask acknowledged by the keyboard              |
// |   busy               sequence in progress                                 |
// |   err                one-cycle pulse when a sequence is abandoned        |
// +--------------------------------------------------------------------------+
module ps2_led_controller
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [2:0] led_state,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_nextdata_n,
  output logic [7:0] fwd_data,
  output logic       fwd_ready,
  input  logic       fwd_nextdata_n,
  output logic [2:0] led_applied,
  output logic       busy,
  output logic       err
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = '1;
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);

  led_ctrl_state_t  r_state;
  logic [2:0]       r_mask_snap;
  logic [2:0]       r_fail_mask;
  logic             r_fail_valid;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [RTY_W-1:0] r_retry;

  logic w_waiting;
  logic w_got_ack;
  logic w_got_resend;
  logic w_timeout;
  logic w_retry_ok;
  logic w_pending;

  assign w_waiting  = (r_state == WAIT_CMD) || (r_state == WAIT_ARG);
  assign w_timeout  = (r_tmo_cnt == TMO_LAST);
  assign w_retry_ok = (r_retry < RTY_LIMIT);
  // A mask that was just abandoned is not retried until led_state moves on
  assign w_pending  = (led_state != led_applied) &&
                      !(r_fail_valid && (led_state == r_fail_mask));
  assign busy       = (r_state != IDLE);

  ps2_rx_arbiter u_rx_arbiter (
    .clk            (clk),
    .clrn           (clrn),
    .waiting        (w_waiting),
    .tx_busy        (tx_busy),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .rx_nextdata_n  (rx_nextdata_n),
    .fwd_data       (fwd_data),
    .fwd_ready      (fwd_ready),
    .fwd_nextdata_n (fwd_nextdata_n),
    .got_ack        (w_got_ack),
    .got_resend     (w_got_resend)
  );

  always_ff @(posedge clk) begin
    if (clrn) begin
      r_state      <= IDLE;
      r_mask_snap  <= '0;
      r_fail_mask  <= '0;
      r_fail_valid <= 1'b0;
      r_tmo_cnt    <= '0;
      r_retry      <= '0;
      tx_data      <= '0;
      tx_start     <= 1'b0;
      led_applied  <= '0;
      err          <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pending) begin
            r_mask_snap <= led_state;
            r_retry     <= '0;
            r_state     <= SEND_CMD;
          end
        end

        SEND_CMD: begin
          if (!tx_busy) begin
            tx_start  <= 1'b1;
            tx_data   <= PS2_CMD_SET_LED;
            r_tmo_cnt <= '0;
            r_state   <= WAIT_CMD;
          end
        end

        WAIT_CMD: begin
          // Only idle-transmitter time counts toward the reply timeout
          if (!tx_busy && (r_tmo_cnt != TMO_MAX)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
          // Reply is checked first so it wins over a coincident timeout
          if (w_got_ack) begin
            r_retry <= '0;
            r_state <= SEND_ARG;
          end else if (w_got_resend || w_timeout) begin
            if (w_retry_ok) begin
              r_retry <= r_retry + 1'b1;
              r_state <= SEND_CMD;
            end else begin
              r_state <= FAIL;
            end
          end
        end

        SEND_ARG: begin
          if (!tx_busy) begin
            tx_start  <= 1'b1;
            tx_data   <= {5'b0, r_mask_snap};
            r_tmo_cnt <= '0;
            r_state   <= WAIT_ARG;
          end
        end

        WAIT_ARG: begin
          if (!tx_busy && (r_tmo_cnt != TMO_MAX)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
          if (w_got_ack) begin
            led_applied  <= r_mask_snap;
            r_fail_valid <= 1'b0;
            r_state      <= IDLE;
          end else if (w_got_resend || w_timeout) begin
            if (w_retry_ok) begin
              r_retry <= r_retry + 1'b1;
              r_state <= SEND_ARG;
            end else begin
              r_state <= FAIL;
            end
          end
        end

        FAIL: begin
          err          <= 1'b1;
          r_fail_mask  <= r_mask_snap;
          r_fail_valid <= 1'b1;
          r_state      <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
